cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit RISC CPU.
- Steps each instruction through fetch, decode, execute and writeback.
- Handshakes with instruction memory. Consumes the decoder's 3-bit opcode plus the ALU zero flag.
- Drives every load/enable strobe for the PC, IR, register file, ALU and flag register.

Parameters:
- RESET_STATE, 0 (IDLE), state entered on reset; 0 = IDLE (waits for run), 1 = FETCH (auto-start).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; leaves IDLE when high
- mem_ready  in  1  instruction memory has valid data this cycle
- opcode  in  3  decoded instr[7:5] from the IR (valid from DECODE onward)
- zero_flag  in  1  registered ALU zero flag
- mem_req  out  1  instruction fetch request
- ir_load  out  1  latch memory data into IR
- pc_inc  out  1  PC <= PC + 1
- pc_load  out  1  PC <= imm (jump)
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
- alu_src_imm  out  1  ALU/regfile B operand is imm instead of register src
- flag_we  out  1  update zero flag from ALU result
- reg_we  out  1  write result to register rd
- halted  out  1  HALT executed
- state_dbg  out  3  current state encoding

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high: on a rising clk edge with rst=1, state <= RESET_STATE.
- Outputs are combinational from the registered state and the opcode input, with no output registers. In IDLE every output except state_dbg is 0.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5. Encodings 6 and 7 are illegal and return to IDLE on the next clock.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: mem_req=1.
  - mem_ready=0: stay; hold mem_req; no other strobes.
  - mem_ready=1: ir_load=1 and pc_inc=1 in the same cycle; go to DECODE.
- DECODE: no strobes; one cycle for the IR and decoder outputs to settle; go to EXECUTE.
- EXECUTE, by opcode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: alu_op = opcode[1:0]; alu_src_imm=0; flag_we=1; go to WRITEBACK.
  - 100 LDI: alu_src_imm=1; go to WRITEBACK.
  - 101 MOV: alu_src_imm=0; go to WRITEBACK.
  - 110 JZ: pc_load = zero_flag; go to FETCH. pc_load wins over any pc_inc; the two are never asserted together.
  - 111 HALT: go to HALT.
- WRITEBACK: reg_we=1; alu_op and alu_src_imm hold their EXECUTE values; go to FETCH.
- HALT: halted=1. Only rst exits; run is ignored.
- run is sampled only in IDLE. Deasserting run mid-instruction has no effect.
- Latency per instruction, with mem_ready high in the first FETCH cycle: ALU/LDI/MOV = 4 cycles; JZ = 3 cycles.
- Each extra cycle mem_ready is low in FETCH adds one cycle.
- rst in any state, including mid-FETCH with mem_req high, forces RESET_STATE at that edge; all strobes drop at the next cycle.
- opcode is ignored outside DECODE, EXECUTE and WRITEBACK.

Optional Feature:
- Macro: CPU_CTRL_PERF_CNT_EN.
- With the macro: adds outputs retired_cnt [15:0] and stall_cnt [15:0].
  - retired_cnt increments on leaving WRITEBACK, on leaving EXECUTE for JZ, and on entering HALT.
  - stall_cnt increments each FETCH cycle with mem_ready=0.
  - Both counters wrap at 16'hFFFF to 0 and clear on rst.
- Without the macro: neither the ports nor the counter logic exist.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_ADD..OP_HALT (3 bits);
  - ALU_ADD..ALU_OR (2 bits);
  - state encodings ST_IDLE..ST_HALT (3 bits).
- The decoder and ALU use the same package.
- Single module. There is no natural sub-module; the optional counters stay inline under the macro.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then run=0 for 5 cycles -> state_dbg=0, all strobes 0. run=1 -> FETCH next cycle, mem_req=1.
2. ADD with zero-wait memory: opcode=000, mem_ready=1 -> cycle1 ir_load=pc_inc=1; cycle3 flag_we=1, alu_op=00; cycle4 reg_we=1; cycle5 back in FETCH.
3. Fetch stall: mem_ready low for 3 cycles then high -> mem_req high for 4 cycles, ir_load pulses once in cycle 4. With the macro, stall_cnt=3.
4. JZ: opcode=110 with zero_flag=1 -> pc_load=1 in EXECUTE, reg_we never asserted. Repeat with zero_flag=0 -> pc_load=0. Both return to FETCH after 3 cycles.
5. LDI then HALT: LDI -> alu_src_imm=1 in EXECUTE and WRITEBACK, reg_we=1. HALT -> halted=1 stays set for 10 cycles with run toggling; rst clears it.
6. Reset mid-fetch: assert rst while in FETCH with mem_ready=0 -> IDLE next cycle, mem_req=0. With the macro, retired_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, ALU operation codes
// and control-sequencer state encodings. Used by the sequencer, decoder
// and ALU so all three agree on the same numbering.
package cpu_pkg;

    // Instruction opcodes (instr[7:5])
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_LDI  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // ALU operation select
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // Sequencer state encodings (6 and 7 are illegal)
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_FETCH     = ST_FETCH,
        S_DECODE    = ST_DECODE,
        S_EXECUTE   = ST_EXECUTE,
        S_WRITEBACK = ST_WRITEBACK,
        S_HALT      = ST_HALT
    } state_t;

    // True for the four register-register ALU instructions
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 8-bit RISC CPU.
// Steps every instruction through FETCH -> DECODE -> EXECUTE -> WRITEBACK
// (JZ returns from EXECUTE, HALT parks until reset). All strobes are
// decoded combinationally from the state register and the opcode input.
// Optional macro CPU_CTRL_PERF_CNT_EN adds retired/stall performance counters.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int RESET_STATE = 0   // 0: start in IDLE, 1: start in FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mem_ready,
    input  logic [2:0] opcode,
    input  logic       zero_flag,
    output logic       mem_req,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic       flag_we,
    output logic       reg_we,
    output logic       halted,
    output logic [2:0] state_dbg
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam state_t RST_ST = (RESET_STATE == 1) ? S_FETCH : S_IDLE;

    state_t state_q;
    state_t state_d;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_ST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (opcode == OP_JZ) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Strobe decode; ALU controls are driven in EXECUTE and held through
    // WRITEBACK so the register-file write sees the same operand/result
    always_comb begin
        mem_req     = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        flag_we     = 1'b0;
        reg_we      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ready;
                pc_inc  = mem_ready;
            end
            S_EXECUTE: begin
                if (is_alu_op(opcode)) begin
                    alu_op  = opcode[1:0];
                    flag_we = 1'b1;
                end
                alu_src_imm = (opcode == OP_LDI);
                // pc_inc is never raised here, so a taken jump is exclusive
                pc_load     = (opcode == OP_JZ) && zero_flag;
            end
            S_WRITEBACK: begin
                if (is_alu_op(opcode)) begin
                    alu_op = opcode[1:0];
                end
                alu_src_imm = (opcode == OP_LDI);
                reg_we      = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_dbg = state_q;

`ifdef CPU_CTRL_PERF_CNT_EN
    logic [15:0] retired_q, retired_d;
    logic [15:0] stall_q, stall_d;
    logic        retire_ev;
    logic        stall_ev;

    // An instruction retires when it leaves WRITEBACK, leaves EXECUTE as a
    // JZ, or enters HALT from EXECUTE
    always_comb begin
        retire_ev = (state_q == S_WRITEBACK) ||
                    ((state_q == S_EXECUTE) &&
                     ((opcode == OP_JZ) || (opcode == OP_HALT)));
        stall_ev  = (state_q == S_FETCH) && !mem_ready;
        retired_d = retire_ev ? retired_q + 16'd1 : retired_q;
        stall_d   = stall_ev  ? stall_q + 16'd1   : stall_q;
    end

    // Wrapping performance counters, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= 16'd0;
            stall_q   <= 16'd0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a driver applies one directed vector
// per clock and queues the hand-computed output vector for that cycle; a
// monitor pops and compares on the falling edge.
module tb_cpu_ctrl_fsm;
    import cpu_pkg::*;

    logic       clk;
    logic       rst;
    logic       run;
    logic       mem_ready;
    logic [2:0] opcode;
    logic       zero_flag;
    logic       mem_req;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       flag_we;
    logic       reg_we;
    logic       halted;
    logic [2:0] state_dbg;
`ifdef CPU_CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;
`endif

    cpu_ctrl_fsm #(.RESET_STATE(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_ready   (mem_ready),
        .opcode      (opcode),
        .zero_flag   (zero_flag),
        .mem_req     (mem_req),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .flag_we     (flag_we),
        .reg_we      (reg_we),
        .halted      (halted),
        .state_dbg   (state_dbg)
`ifdef CPU_CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Output vector: {state, mem_req, ir_load, pc_inc, pc_load, alu_op, imm, flag_we, reg_we, halted}
    function automatic logic [12:0] ev(input logic [2:0] st, input logic mrq, input logic irl,
                                       input logic pci, input logic pcl, input logic [1:0] aop,
                                       input logic imm, input logic fwe, input logic rwe,
                                       input logic hlt);
        return {st, mrq, irl, pci, pcl, aop, imm, fwe, rwe, hlt};
    endfunction

    logic [12:0] act;
    assign act = {state_dbg, mem_req, ir_load, pc_inc, pc_load, alu_op,
                  alu_src_imm, flag_we, reg_we, halted};

    // Monitor: compare every queued expectation in the cycle it was issued
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b required %b (st mrq irl pci pcl aop imm fwe rwe hlt)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs, advance a clock
    task automatic cyc(input logic r, input logic rn, input logic mr, input logic [2:0] op,
                       input logic zf, input logic [12:0] exp, input string nm);
        sb_entry_t e;
        rst       = r;
        run       = rn;
        mem_ready = mr;
        opcode    = op;
        zero_flag = zf;
        e.exp     = exp;
        e.name    = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

`ifdef CPU_CTRL_PERF_CNT_EN
    task automatic chk_cnt(input logic [15:0] a, input logic [15:0] x, input string nm);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, a, x);
        end
    endtask
`endif

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    localparam logic [12:0] E_IDLE  = 13'b000_0000_00_0000;
    localparam logic [12:0] E_FWAIT = 13'b001_1000_00_0000;
    localparam logic [12:0] E_FGO   = 13'b001_1110_00_0000;
    localparam logic [12:0] E_DEC   = 13'b010_0000_00_0000;
    localparam logic [12:0] E_HALT  = 13'b101_0000_00_0001;

    // Directed stimulus
    initial begin
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 3'd0; zero_flag = 1'b0;
        @(posedge clk);
        #1;

        // Reset and idle
        cyc(1, 0, 0, OP_ADD, 0, E_IDLE, "reset_hold");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, OP_ADD, 0, E_IDLE, "idle_wait");
        cyc(0, 1, 0, OP_ADD, 0, E_IDLE, "idle_run");

        // ADD, zero-wait fetch (run dropped: no effect mid-instruction)
        cyc(0, 0, 1, OP_ADD, 0, E_FGO, "add_fetch");
        cyc(0, 0, 0, OP_ADD, 0, E_DEC, "add_decode");
        cyc(0, 0, 0, OP_ADD, 0, ev(3'd3, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), "add_execute");
        cyc(0, 0, 0, OP_ADD, 0, ev(3'd4, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0), "add_writeback");

        // AND with a 3-cycle fetch stall
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, OP_ADD, 0, E_FWAIT, "stall_fetch");
        cyc(0, 0, 1, OP_ADD, 0, E_FGO, "and_fetch");
        cyc(0, 0, 0, OP_AND, 0, E_DEC, "and_decode");
        cyc(0, 0, 0, OP_AND, 0, ev(3'd3, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0), "and_execute");
        cyc(0, 0, 0, OP_AND, 0, ev(3'd4, 0, 0, 0, 0, 2'b10, 0, 0, 1, 0), "and_writeback");
`ifdef CPU_CTRL_PERF_CNT_EN
        chk_cnt(stall_cnt, 16'd3, "stall_cnt_after_stall");
`endif

        // JZ taken then not taken
        cyc(0, 0, 1, OP_AND, 0, E_FGO, "jz1_fetch");
        cyc(0, 0, 0, OP_JZ, 1, E_DEC, "jz1_decode");
        cyc(0, 0, 0, OP_JZ, 1, ev(3'd3, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), "jz1_execute");
        cyc(0, 0, 1, OP_JZ, 1, E_FGO, "jz0_fetch");
        cyc(0, 0, 0, OP_JZ, 0, E_DEC, "jz0_decode");
        cyc(0, 0, 0, OP_JZ, 0, ev(3'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "jz0_execute");

        // SUB
        cyc(0, 0, 1, OP_JZ, 0, E_FGO, "sub_fetch");
        cyc(0, 0, 0, OP_SUB, 0, E_DEC, "sub_decode");
        cyc(0, 0, 0, OP_SUB, 0, ev(3'd3, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0), "sub_execute");
        cyc(0, 0, 0, OP_SUB, 0, ev(3'd4, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0), "sub_writeback");

        // MOV
        cyc(0, 0, 1, OP_SUB, 0, E_FGO, "mov_fetch");
        cyc(0, 0, 0, OP_MOV, 0, E_DEC, "mov_decode");
        cyc(0, 0, 0, OP_MOV, 0, ev(3'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "mov_execute");
        cyc(0, 0, 0, OP_MOV, 0, ev(3'd4, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0), "mov_writeback");

        // LDI
        cyc(0, 0, 1, OP_MOV, 0, E_FGO, "ldi_fetch");
        cyc(0, 0, 0, OP_LDI, 0, E_DEC, "ldi_decode");
        cyc(0, 0, 0, OP_LDI, 0, ev(3'd3, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0), "ldi_execute");
        cyc(0, 0, 0, OP_LDI, 0, ev(3'd4, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0), "ldi_writeback");

        // HALT, run toggling, reset exit
        cyc(0, 0, 1, OP_LDI, 0, E_FGO, "halt_fetch");
        cyc(0, 0, 0, OP_HALT, 0, E_DEC, "halt_decode");
        cyc(0, 0, 0, OP_HALT, 0, ev(3'd3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "halt_execute");
`ifdef CPU_CTRL_PERF_CNT_EN
        chk_cnt(retired_cnt, 16'd8, "retired_cnt_at_halt");
`endif
        for (int i = 0; i < 10; i++) cyc(0, i[0], 0, OP_HALT, 0, E_HALT, "halt_hold");
        cyc(1, 0, 0, OP_HALT, 0, E_HALT, "halt_rst_edge");
        cyc(0, 0, 0, OP_HALT, 0, E_IDLE, "halt_cleared");
`ifdef CPU_CTRL_PERF_CNT_EN
        chk_cnt(retired_cnt, 16'd0, "retired_cnt_after_rst");
`endif

        // Reset in the middle of a stalled fetch
        cyc(0, 1, 0, OP_ADD, 0, E_IDLE, "idle_run2");
        cyc(1, 0, 0, OP_ADD, 0, E_FWAIT, "fetch_rst_edge");
        cyc(0, 0, 0, OP_ADD, 0, E_IDLE, "fetch_rst_idle");
`ifdef CPU_CTRL_PERF_CNT_EN
        chk_cnt(retired_cnt, 16'd0, "retired_cnt_mid_fetch_rst");
        chk_cnt(stall_cnt, 16'd0, "stall_cnt_mid_fetch_rst");
`endif

        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
